// File: rtl/ysyx_040750_store_ctrl.sv
// LSU store-side write controller: accepts one store from MEM, builds lane-replicated
// data and byte strobe, and drives a single AXI4-lite AW/W/B write transaction.
module ysyx_040750_store_ctrl #(
  parameter int ADDR_W = 32
) (
  input  logic              I_clk,
  input  logic              I_rst_n,
  input  logic              I_st_valid,
  output logic              O_st_ready,
  input  logic [ADDR_W-1:0] I_st_addr,
  input  logic [1:0]        I_st_size,
  input  logic [63:0]       I_st_data,
  output logic              O_st_done,
  output logic              O_st_err,
  output logic              O_awvalid,
  input  logic              I_awready,
  output logic [ADDR_W-1:0] O_awaddr,
  output logic              O_wvalid,
  input  logic              I_wready,
  output logic [63:0]       O_wdata,
  output logic [7:0]        O_wstrb,
  input  logic              I_bvalid,
  output logic              O_bready,
  input  logic [1:0]        I_bresp
);

  typedef enum logic [1:0] {IDLE, XFER, WAIT_B, RESP} state_e;

  state_e            state_q;
  logic              awvalid_q;
  logic              wvalid_q;
  logic              bready_q;
  logic              done_q;
  logic              err_q;
  logic [ADDR_W-1:0] addr_q;
  logic [63:0]       data_q;
  logic [7:0]        strb_q;

  logic              misaligned_d;
  logic [7:0]        strb_base_d;
  logic [7:0]        strb_d;
  logic [63:0]       wdata_d;
  logic              aw_fin_d;
  logic              w_fin_d;

  always_comb begin
    misaligned_d = 1'b0;
    strb_base_d  = 8'h01;
    wdata_d      = I_st_data;
    case (I_st_size)
      2'd0: begin
        strb_base_d = 8'h01;
        wdata_d     = {8{I_st_data[7:0]}};
      end
      2'd1: begin
        strb_base_d  = 8'h03;
        wdata_d      = {4{I_st_data[15:0]}};
        misaligned_d = I_st_addr[0];
      end
      2'd2: begin
        strb_base_d  = 8'h0F;
        wdata_d      = {2{I_st_data[31:0]}};
        misaligned_d = (I_st_addr[1:0] != 2'b00);
      end
      default: begin
        strb_base_d  = 8'hFF;
        wdata_d      = I_st_data;
        misaligned_d = (I_st_addr[2:0] != 3'b000);
      end
    endcase
    strb_d = strb_base_d << I_st_addr[2:0];
  end

  // In XFER a dropped valid means that channel's handshake already happened.
  assign aw_fin_d = !awvalid_q || I_awready;
  assign w_fin_d  = !wvalid_q || I_wready;

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_q   <= IDLE;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      strb_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (I_st_valid) begin
            addr_q <= I_st_addr;
            data_q <= wdata_d;
            strb_q <= strb_d;
            if (misaligned_d) begin
              err_q   <= 1'b1;
              done_q  <= 1'b1;
              state_q <= RESP;
            end else begin
              err_q     <= 1'b0;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              state_q   <= XFER;
            end
          end
        end
        XFER: begin
          if (awvalid_q && I_awready) awvalid_q <= 1'b0;
          if (wvalid_q && I_wready) wvalid_q <= 1'b0;
          if (aw_fin_d && w_fin_d) begin
            bready_q <= 1'b1;
            state_q  <= WAIT_B;
          end
        end
        WAIT_B: begin
          if (I_bvalid) begin
            bready_q <= 1'b0;
            err_q    <= (I_bresp != 2'b00);
            done_q   <= 1'b1;
            state_q  <= RESP;
          end
        end
        default: begin
          // err is only meaningful alongside the done pulse, so clear it here.
          err_q   <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign O_st_ready = (state_q == IDLE) && I_rst_n;
  assign O_st_done  = done_q;
  assign O_st_err   = err_q;
  assign O_awvalid  = awvalid_q;
  assign O_awaddr   = addr_q;
  assign O_wvalid   = wvalid_q;
  assign O_wdata    = data_q;
  assign O_wstrb    = strb_q;
  assign O_bready   = bready_q;

endmodule

// File: tb/tb_ysyx_040750_store_ctrl.sv
// Table-driven bench for the store controller with a small AXI4-lite write slave.
module tb_ysyx_040750_store_ctrl;

  logic        clk;
  logic        rst_n;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr;
  logic [1:0]  st_size;
  logic [63:0] st_data;
  logic        st_done;
  logic        st_err;
  logic        awvalid;
  logic        awready;
  logic [31:0] awaddr;
  logic        wvalid;
  logic        wready;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        bvalid;
  logic        bready;
  logic [1:0]  bresp;

  ysyx_040750_store_ctrl #(.ADDR_W(32)) dut (
    .I_clk(clk), .I_rst_n(rst_n),
    .I_st_valid(st_valid), .O_st_ready(st_ready),
    .I_st_addr(st_addr), .I_st_size(st_size), .I_st_data(st_data),
    .O_st_done(st_done), .O_st_err(st_err),
    .O_awvalid(awvalid), .I_awready(awready), .O_awaddr(awaddr),
    .O_wvalid(wvalid), .I_wready(wready), .O_wdata(wdata), .O_wstrb(wstrb),
    .I_bvalid(bvalid), .O_bready(bready), .I_bresp(bresp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write slave: raises bvalid the cycle after both AW and W have handshaken.
  logic aw_got, w_got, b_hold;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_got <= 1'b0;
      w_got  <= 1'b0;
      bvalid <= 1'b0;
    end else if (bvalid && bready) begin
      bvalid <= 1'b0;
      aw_got <= 1'b0;
      w_got  <= 1'b0;
    end else begin
      if (awvalid && awready) aw_got <= 1'b1;
      if (wvalid && wready) w_got <= 1'b1;
      if (!b_hold && !bvalid && (aw_got || (awvalid && awready)) && (w_got || (wvalid && wready)))
        bvalid <= 1'b1;
    end
  end

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  size;
    logic [63:0] data;
    logic [1:0]  bresp;
    int          aw_delay;
    logic [7:0]  exp_strb;
    logic [63:0] exp_wdata;
    logic        exp_err;
    int          exp_done;
    int          exp_aw_cyc;
    int          exp_w_cyc;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs [NV];

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] a, input logic [1:0] s, input logic [63:0] d,
                              input logic [1:0] br, input int dly, input logic [7:0] es,
                              input logic [63:0] ed, input logic ee, input int edone,
                              input int eaw, input int ew);
    vec_t v;
    v.addr = a; v.size = s; v.data = d; v.bresp = br; v.aw_delay = dly;
    v.exp_strb = es; v.exp_wdata = ed; v.exp_err = ee; v.exp_done = edone;
    v.exp_aw_cyc = eaw; v.exp_w_cyc = ew;
    return v;
  endfunction

  // Results of the most recent do_store; cycle 1 is the cycle after the accept edge.
  int          r_done_cyc, r_aw_cyc, r_w_cyc;
  logic        r_err, r_ready_req, r_post_ready, r_post_done, r_aw_stable, r_b_early;
  logic [31:0] r_awaddr;
  logic [7:0]  r_strb;
  logic [63:0] r_wdata;

  task automatic do_store(input logic [31:0] a, input logic [1:0] s, input logic [63:0] d,
                          input logic [1:0] br, input int dly);
    int   cyc;
    logic done_seen, aw_hs;
    @(negedge clk);
    st_valid = 1'b1; st_addr = a; st_size = s; st_data = d;
    bresp = br; awready = 1'b0; wready = 1'b1;
    r_ready_req = st_ready;
    @(posedge clk);
    #1 st_valid = 1'b0;
    cyc = 0; done_seen = 1'b0; aw_hs = 1'b0;
    r_done_cyc = -1; r_aw_cyc = 0; r_w_cyc = 0; r_err = 1'b0;
    r_aw_stable = 1'b1; r_b_early = 1'b0; r_awaddr = '0; r_strb = '0; r_wdata = '0;
    while (!done_seen && cyc < 20) begin
      @(negedge clk);
      cyc++;
      awready = (cyc > dly);
      if (bready && !aw_hs) r_b_early = 1'b1;
      if (awvalid) begin
        r_aw_cyc++;
        if (r_aw_cyc == 1) r_awaddr = awaddr;
        else if (awaddr !== r_awaddr) r_aw_stable = 1'b0;
        if (awready) aw_hs = 1'b1;
      end
      if (wvalid) begin
        r_w_cyc++;
        r_strb  = wstrb;
        r_wdata = wdata;
      end
      if (st_done) begin
        done_seen  = 1'b1;
        r_done_cyc = cyc;
        r_err      = st_err;
      end
    end
    @(negedge clk);
    r_post_ready = st_ready;
    r_post_done  = st_done;
    awready = 1'b0;
  endtask

  initial begin
    int   n;
    logic seen_bready, no_done;

    vecs[0] = mk(32'h8000_0005, 2'd0, 64'hAB, 2'b00, 0, 8'h20, 64'hABAB_ABAB_ABAB_ABAB, 1'b0, 3, 1, 1);
    vecs[1] = mk(32'h8000_0004, 2'd2, 64'h1122_3344_5566_7788, 2'b00, 0, 8'hF0, 64'h5566_7788_5566_7788, 1'b0, 3, 1, 1);
    vecs[2] = mk(32'h8000_0000, 2'd3, 64'h1122_3344_5566_7788, 2'b00, 0, 8'hFF, 64'h1122_3344_5566_7788, 1'b0, 3, 1, 1);
    vecs[3] = mk(32'h8000_0003, 2'd1, 64'hBEEF, 2'b00, 0, 8'h00, 64'h0, 1'b1, 1, 0, 0);
    vecs[4] = mk(32'h8000_0006, 2'd1, 64'hCAFE, 2'b00, 0, 8'hC0, 64'hCAFE_CAFE_CAFE_CAFE, 1'b0, 3, 1, 1);
    vecs[5] = mk(32'h8000_0010, 2'd2, 64'hDEAD_BEEF, 2'b00, 3, 8'h0F, 64'hDEAD_BEEF_DEAD_BEEF, 1'b0, 6, 4, 1);
    vecs[6] = mk(32'h8000_0018, 2'd3, 64'h0123_4567_89AB_CDEF, 2'b10, 0, 8'hFF, 64'h0123_4567_89AB_CDEF, 1'b1, 3, 1, 1);
    vecs[7] = mk(32'h8000_0001, 2'd0, 64'hFFFF_0000_1111_225A, 2'b00, 0, 8'h02, 64'h5A5A_5A5A_5A5A_5A5A, 1'b0, 3, 1, 1);
    vecs[8] = mk(32'h8000_0004, 2'd3, 64'h1, 2'b00, 0, 8'h00, 64'h0, 1'b1, 1, 0, 0);
    vecs[9] = mk(32'h8000_0002, 2'd2, 64'h2, 2'b00, 0, 8'h00, 64'h0, 1'b1, 1, 0, 0);

    rst_n = 1'b0; st_valid = 1'b0; st_addr = '0; st_size = '0; st_data = '0;
    awready = 1'b0; wready = 1'b0; bresp = 2'b00; b_hold = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 64'(st_ready), 64'd0);
    chk("rst_awvalid", 64'(awvalid), 64'd0);
    chk("rst_wvalid", 64'(wvalid), 64'd0);
    chk("rst_bready", 64'(bready), 64'd0);
    chk("rst_done", 64'(st_done), 64'd0);
    chk("rst_err", 64'(st_err), 64'd0);
    chk("rst_regs", 64'(awaddr) | wdata | 64'(wstrb), 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      do_store(vecs[i].addr, vecs[i].size, vecs[i].data, vecs[i].bresp, vecs[i].aw_delay);
      $display("store %0d addr=%h size=%0d done_cyc=%0d err=%0d aw_cyc=%0d w_cyc=%0d strb=%h wdata=%h",
               i, vecs[i].addr, vecs[i].size, r_done_cyc, r_err, r_aw_cyc, r_w_cyc, r_strb, r_wdata);
      chk($sformatf("v%0d_ready_at_req", i), 64'(r_ready_req), 64'd1);
      chk($sformatf("v%0d_done_cycle", i), 64'(r_done_cyc), 64'(vecs[i].exp_done));
      chk($sformatf("v%0d_err", i), 64'(r_err), 64'(vecs[i].exp_err));
      chk($sformatf("v%0d_awvalid_cycles", i), 64'(r_aw_cyc), 64'(vecs[i].exp_aw_cyc));
      chk($sformatf("v%0d_wvalid_cycles", i), 64'(r_w_cyc), 64'(vecs[i].exp_w_cyc));
      chk($sformatf("v%0d_done_one_cycle", i), 64'(r_post_done), 64'd0);
      chk($sformatf("v%0d_ready_after", i), 64'(r_post_ready), 64'd1);
      if (vecs[i].exp_aw_cyc > 0) begin
        chk($sformatf("v%0d_awaddr", i), 64'(r_awaddr), 64'(vecs[i].addr));
        chk($sformatf("v%0d_awaddr_stable", i), 64'(r_aw_stable), 64'd1);
        chk($sformatf("v%0d_wstrb", i), 64'(r_strb), 64'(vecs[i].exp_strb));
        chk($sformatf("v%0d_wdata", i), r_wdata, vecs[i].exp_wdata);
        chk($sformatf("v%0d_bready_after_aw", i), 64'(r_b_early), 64'd0);
      end
    end

    // Reset asserted mid-cycle while the controller waits for a write response.
    b_hold = 1'b1;
    @(negedge clk);
    st_valid = 1'b1; st_addr = 32'h8000_0008; st_size = 2'd3; st_data = 64'h55;
    awready = 1'b1; wready = 1'b1;
    @(posedge clk);
    #1 st_valid = 1'b0;
    n = 0; seen_bready = 1'b0;
    while (!seen_bready && n < 10) begin
      @(negedge clk);
      n++;
      seen_bready = bready;
    end
    chk("wait_b_reached", 64'(seen_bready), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    $display("reset mid WAIT_B: awvalid=%0d wvalid=%0d bready=%0d done=%0d ready=%0d",
             awvalid, wvalid, bready, st_done, st_ready);
    chk("rstmid_valids", 64'({awvalid, wvalid, bready}), 64'd0);
    chk("rstmid_done", 64'(st_done), 64'd0);
    chk("rstmid_ready", 64'(st_ready), 64'd0);
    no_done = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (st_done) no_done = 1'b0;
    end
    chk("rstmid_no_done", 64'(no_done), 64'd1);
    b_hold = 1'b0; awready = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("ready_after_release", 64'(st_ready), 64'd1);

    do_store(32'h8000_0007, 2'd0, 64'h3C, 2'b00, 0);
    $display("post-reset store done_cyc=%0d err=%0d strb=%h wdata=%h", r_done_cyc, r_err, r_strb, r_wdata);
    chk("post_rst_done_cycle", 64'(r_done_cyc), 64'd3);
    chk("post_rst_err", 64'(r_err), 64'd0);
    chk("post_rst_wstrb", 64'(r_strb), 64'h80);
    chk("post_rst_wdata", r_wdata, 64'h3C3C_3C3C_3C3C_3C3C);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
